// File: rtl/axi4_burst_master_if.sv
// AXI4 master-side bus bundle (AW/W/B/AR/R) for axi4_burst_master.
// The master modport is the initiator view and the slave modport is the memory view.
interface axi4_burst_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    localparam int STRB_W = DATA_W / 8;

    logic [ID_W-1:0]   aw_id;
    logic [ADDR_W-1:0] aw_addr;
    logic [7:0]        aw_len;
    logic [2:0]        aw_size;
    logic [1:0]        aw_burst;
    logic              aw_lock;
    logic [3:0]        aw_cache;
    logic [2:0]        aw_prot;
    logic [3:0]        aw_qos;
    logic              aw_valid;
    logic              aw_ready;

    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              w_last;
    logic              w_valid;
    logic              w_ready;

    logic              b_valid;
    logic [ID_W-1:0]   b_id;
    logic [1:0]        b_resp;
    logic              b_ready;

    logic [ID_W-1:0]   ar_id;
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;
    logic              ar_lock;
    logic [3:0]        ar_cache;
    logic [2:0]        ar_prot;
    logic [3:0]        ar_qos;
    logic              ar_valid;
    logic              ar_ready;

    logic              r_valid;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;
    logic              r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_valid, b_id, b_resp,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_valid,
        input  ar_ready,
        input  r_valid, r_id, r_data, r_resp, r_last,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_valid, b_id, b_resp,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_valid,
        output ar_ready,
        output r_valid, r_id, r_data, r_resp, r_last,
        input  r_ready
    );
endinterface

// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator: one command becomes one read or write burst,
// with a one-cycle done pulse carrying the worst response seen and a protocol-error flag.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// AR    | read address offered, waiting for ar_ready
// R     | read beats passed through to the rd stream
// AW    | write address offered, waiting for aw_ready
// W     | write beats passed through from the wr stream
// B     | waiting for the write response
module axi4_burst_master #(
    parameter int          ADDR_W = 32,
    parameter int          DATA_W = 32,
    parameter int          ID_W   = 4,
    parameter int unsigned TXN_ID = 0
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [7:0]            cmd_len,

    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,

    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_last,

    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  done_err,

    axi4_burst_master_if.master   m_axi
);
    localparam int                SIZE_LSB   = $clog2(DATA_W / 8);
    localparam logic [2:0]        BEAT_SIZE  = 3'(SIZE_LSB);
    localparam logic [ID_W-1:0]   ID_CONST   = ID_W'(TXN_ID);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'((64'd1 << SIZE_LSB) - 64'd1));

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW   = 3'd3,
        S_W    = 3'd4,
        S_B    = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [7:0]        beat_cnt;
    logic [1:0]        resp_acc;
    logic              err_q;
    logic              done_q;

    logic              accept;
    logic              r_fire;
    logic              w_fire;
    logic              b_fire;
    logic              final_fire;
    logic              ar_valid_c;
    logic              aw_valid_c;
    logic              w_valid_c;
    logic              r_ready_c;
    logic              b_ready_c;
    logic              cmd_ready_c;
    logic              wr_ready_c;
    logic              rd_valid_c;

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (b > a) ? b : a;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_ready_c = 1'b0;
        ar_valid_c  = 1'b0;
        aw_valid_c  = 1'b0;
        w_valid_c   = 1'b0;
        wr_ready_c  = 1'b0;
        r_ready_c   = 1'b0;
        rd_valid_c  = 1'b0;
        b_ready_c   = 1'b0;
        accept      = 1'b0;
        r_fire      = 1'b0;
        w_fire      = 1'b0;
        b_fire      = 1'b0;
        final_fire  = 1'b0;
        case (state)
            S_IDLE: begin
                // cmd_ready must read low for the whole reset cycle, even though state is already IDLE
                cmd_ready_c = ~reset;
                if (cmd_valid && !reset) begin
                    accept    = 1'b1;
                    state_nxt = cmd_write ? S_AW : S_AR;
                end
            end
            S_AR: begin
                ar_valid_c = 1'b1;
                if (m_axi.ar_ready) begin
                    state_nxt = S_R;
                end
            end
            S_R: begin
                r_ready_c  = rd_ready;
                rd_valid_c = m_axi.r_valid;
                if (m_axi.r_valid && rd_ready) begin
                    r_fire = 1'b1;
                    if (m_axi.r_last) begin
                        final_fire = 1'b1;
                        state_nxt  = S_IDLE;
                    end
                end
            end
            S_AW: begin
                aw_valid_c = 1'b1;
                if (m_axi.aw_ready) begin
                    state_nxt = S_W;
                end
            end
            S_W: begin
                w_valid_c  = wr_valid;
                wr_ready_c = m_axi.w_ready;
                if (wr_valid && m_axi.w_ready) begin
                    w_fire = 1'b1;
                    if (beat_cnt == len_q) begin
                        state_nxt = S_B;
                    end
                end
            end
            S_B: begin
                b_ready_c = 1'b1;
                if (m_axi.b_valid) begin
                    b_fire     = 1'b1;
                    final_fire = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            resp_acc <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= final_fire;
            if (accept) begin
                addr_q   <= cmd_addr & ALIGN_MASK;
                len_q    <= cmd_len;
                beat_cnt <= '0;
                resp_acc <= '0;
                err_q    <= 1'b0;
            end
            if (r_fire) begin
                beat_cnt <= beat_cnt + 8'd1;
                resp_acc <= resp_max(resp_acc, m_axi.r_resp);
                // early last, missing last, or foreign ID all flag the burst as malformed
                if ((m_axi.r_id != ID_CONST) ||
                    (m_axi.r_last && (beat_cnt != len_q)) ||
                    (!m_axi.r_last && (beat_cnt == len_q))) begin
                    err_q <= 1'b1;
                end
            end
            if (w_fire) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (b_fire) begin
                resp_acc <= resp_max(resp_acc, m_axi.b_resp);
                if (m_axi.b_id != ID_CONST) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign cmd_ready = cmd_ready_c;
    assign wr_ready  = wr_ready_c;
    assign rd_valid  = rd_valid_c;
    assign rd_data   = m_axi.r_data;
    assign rd_last   = m_axi.r_last;
    assign done      = done_q;
    assign done_resp = resp_acc;
    assign done_err  = err_q;

    assign m_axi.aw_id    = ID_CONST;
    assign m_axi.aw_addr  = addr_q;
    assign m_axi.aw_len   = len_q;
    assign m_axi.aw_size  = BEAT_SIZE;
    assign m_axi.aw_burst = 2'b01;
    assign m_axi.aw_lock  = 1'b0;
    assign m_axi.aw_cache = 4'b0011;
    assign m_axi.aw_prot  = 3'b000;
    assign m_axi.aw_qos   = 4'b0000;
    assign m_axi.aw_valid = aw_valid_c;

    assign m_axi.w_data   = wr_data;
    assign m_axi.w_strb   = wr_strb;
    assign m_axi.w_last   = (state == S_W) && (beat_cnt == len_q);
    assign m_axi.w_valid  = w_valid_c;

    assign m_axi.b_ready  = b_ready_c;

    assign m_axi.ar_id    = ID_CONST;
    assign m_axi.ar_addr  = addr_q;
    assign m_axi.ar_len   = len_q;
    assign m_axi.ar_size  = BEAT_SIZE;
    assign m_axi.ar_burst = 2'b01;
    assign m_axi.ar_lock  = 1'b0;
    assign m_axi.ar_cache = 4'b0011;
    assign m_axi.ar_prot  = 3'b000;
    assign m_axi.ar_qos   = 4'b0000;
    assign m_axi.ar_valid = ar_valid_c;

    assign m_axi.r_ready  = r_ready_c;
endmodule

// File: doc/axi4_burst_master.md
Name: axi4_burst_master

Overview:
AXI4 initiator that turns simple accelerator memory commands into single-ID INCR bursts toward the DDR-backed AXI4 memory port. It sits between the RoCC accelerator datapath and the memory subsystem's AXI4 slave port, on the `clock` domain. It issues one read or write burst at a time. Write data arrives on a valid/ready stream and read data leaves on one; a completion pulse carries the merged response.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; beat size fixed to log2(DATA_W/8)
- ID_W, 4, AXI ID width
- TXN_ID, 0, constant ID driven on aw_id/ar_id

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block in IDLE and accepting
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  byte address; low log2(DATA_W/8) bits forced to 0
- cmd_len  in  8  beats minus 1 (AXI len)
- wr_valid/wr_ready  in/out  1/1  write data stream handshake
- wr_data  in  DATA_W  write beat
- wr_strb  in  DATA_W/8  byte enables
- rd_valid/rd_ready  out/in  1/1  read data stream handshake
- rd_data  out  DATA_W  read beat
- rd_last  out  1  final read beat
- done  out  1  one-cycle completion pulse
- done_resp  out  2  merged response (worst of all beats/B)
- done_err  out  1  protocol error: beat count vs last mismatch or ID mismatch
- m_axi_aw_*  out  id[ID_W], addr[ADDR_W], len[8], size[3], burst[2], lock, cache[4], prot[3], qos[4], valid; aw_ready in
- m_axi_w_*  out  data, strb, last, valid; w_ready in
- m_axi_b_*  in  valid, id, resp; b_ready out
- m_axi_ar_*  out  same fields as AW; ar_ready in
- m_axi_r_*  in  valid, id, data, resp, last; r_ready out

Behaviour:
- Constants: burst=2'b01 INCR, size=log2(DATA_W/8), lock=0, cache=4'b0011, prot=0, qos=0, id=TXN_ID.
- Reset: state=IDLE; all AXI valids, b_ready, r_ready, wr_ready, rd_valid, done, done_err = 0; done_resp=0; beat counter=0; cmd_ready=0 during reset.
- FSM states: IDLE, AR, R, AW, W, B.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch addr/len/write; clear resp accumulator, counter, and error flag. Go to AW if write, else AR.
- AR: ar_valid=1 with latched fields, held stable until ar_ready. On ar_ready → R.
- R: r_ready=rd_ready; rd_valid=r_valid; rd_data/rd_last pass r_data/r_last combinationally. Each beat is counted on r_valid&r_ready.
  - Accumulate resp as max(acc, r_resp).
  - Set error flag if r_id≠TXN_ID, if r_last=1 with count≠len, or if count==len with r_last=0.
  - On the r_last beat → IDLE and pulse done.
- AW: aw_valid=1 until aw_ready → W. W is not issued before AW completes.
- W: w_valid=wr_valid and wr_ready=w_ready (combinational pass-through). w_last=(count==len). Count increments on w_valid&w_ready. The last beat → B.
- B: b_ready=1. On b_valid: acc=max(acc, b_resp); set error flag if b_id≠TXN_ID; → IDLE and pulse done.
- done: asserted for exactly 1 cycle, the cycle after the final handshake. done_resp and done_err are valid with done and hold until the next command is accepted. cmd_ready returns to 1 in that same cycle.
- Latency: command accept → ar_valid/aw_valid is 1 cycle. The block never has more than one outstanding transaction.
- Boundaries:
  - len=0 gives a single beat with w_last=1 on that beat.
  - len=255 gives 256 beats; the counter is 8 bits and never wraps within a burst.
  - 4KB crossing is not checked; the commander guarantees it.
- Reset mid-burst: synchronous return to IDLE with all valids dropped next edge. The memory slave is reset by the same reset.

Test Plan:
- Read addr 0x100, len=0; slave returns data 0xDEADBEEF, resp OKAY, last=1 → ar_addr=0x100, ar_len=0, ar_size=2; rd_data=0xDEADBEEF with rd_last=1; done pulse with done_resp=0, done_err=0.
- Write addr 0x203 (unaligned), len=3, beats 1..4, w_ready toggling 1/0 → aw_addr=0x200; 4 W beats in order with w_last only on beat 4; done_resp=0 after B.
- 8-beat read with rd_ready low for 3 cycles mid-burst → r_ready follows rd_ready; no beat lost or duplicated; count reaches 7 with rd_last.
- Read len=3, slave asserts r_last on beat 2 and beat 1 resp=SLVERR → done_resp=2'b10, done_err=1, FSM back in IDLE.
- Back-to-back write then read commands → cmd_ready=0 throughout the write, reasserts on the done cycle; second command accepted next cycle.
- reset asserted during W beat 2 of a 4-beat write → next cycle all valids=0, cmd_ready=0 while reset is high, =1 the cycle after release.
